// File: rtl/basic_dp_pkg.sv
// Shared constants for the basic register-transfer datapath.
// Bus-select codes, strobe bit positions, opcodes and IR fields.
package basic_dp_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 12;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_AR   = 3'd1,
    SEL_PC   = 3'd2,
    SEL_DR   = 3'd3,
    SEL_AC   = 3'd4,
    SEL_IR   = 3'd5,
    SEL_TR   = 3'd6,
    SEL_MEM  = 3'd7
  } bus_sel_e;

  // ld is {AR, PC, DR, AC, IR}
  localparam int LD_AR = 4;
  localparam int LD_PC = 3;
  localparam int LD_DR = 2;
  localparam int LD_AC = 1;
  localparam int LD_IR = 0;

  // inr and clr are {AR, PC, DR, AC}
  localparam int RG_AR = 3;
  localparam int RG_PC = 2;
  localparam int RG_DR = 1;
  localparam int RG_AC = 0;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int IR_CMA = 9;
  localparam int IR_CIR = 7;
  localparam int IR_CIL = 6;

endpackage

// File: rtl/basic_datapath_if.sv
// Word-memory port of the datapath.
// master drives address/data/strobes, slave returns read data.
interface basic_datapath_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_re,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_re,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/basic_datapath_bus_encoder.sv
// 8-to-3 priority encoder for the common-bus select lines.
// Highest set bit wins; bit 0 is not a source.
module bus_encoder
  import basic_dp_pkg::*;
(
  input  logic [7:0] x,
  output bus_sel_e   sel,
  output logic       valid
);

  always_comb begin
    sel   = SEL_NONE;
    valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (x[i]) begin
        sel   = bus_sel_e'(3'(i));
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/basic_datapath.sv
// AR/PC/DR/AC/IR/E register file, common bus and AC arithmetic.
// Driven by control strobes; returns IR to the control unit.
module basic_datapath
  import basic_dp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    ld,
  input  logic [3:0]    inr,
  input  logic [3:0]    clr,
  input  logic [7:0]    x,
  input  logic          Read,
  input  logic          Write,
  basic_datapath_if.master mem,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] ac,
  output logic          e,
  output logic [DW-1:0] bus
);

  logic [AW-1:0] ar_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] dr_q;
  logic [DW-1:0] ac_q;
  logic [DW-1:0] ir_q;
  logic          e_q;

  bus_sel_e sel;
  logic     sel_valid;

  bus_encoder u_enc (
    .x     (x),
    .sel   (sel),
    .valid (sel_valid)
  );

  always_comb begin
    bus = '0;
    if (sel_valid) begin
      unique case (sel)
        SEL_MEM: bus = mem.mem_rdata;
        SEL_TR:  bus = '0;
        SEL_IR:  bus = ir_q;
        SEL_AC:  bus = ac_q;
        SEL_DR:  bus = dr_q;
        SEL_PC:  bus = {{(DW-AW){1'b0}}, pc_q};
        SEL_AR:  bus = {{(DW-AW){1'b0}}, ar_q};
        default: bus = '0;
      endcase
    end
  end

  logic [2:0]    opc;
  logic [DW-1:0] ac_n;
  logic          e_n;

  assign opc = ir_q[14:12];

  always_comb begin
    ac_n = dr_q;
    e_n  = e_q;
    unique case (opc)
      OP_AND: ac_n = ac_q & dr_q;
      OP_ADD: {e_n, ac_n} = {1'b0, ac_q} + {1'b0, dr_q};
      OP_LDA: ac_n = dr_q;
      OP_REG: begin
        ac_n = ac_q;
        if (ir_q[IR_CMA])
          ac_n = ~ac_q;
        else if (ir_q[IR_CIR])
          {ac_n, e_n} = {e_q, ac_q};
        else if (ir_q[IR_CIL])
          {e_n, ac_n} = {ac_q, e_q};
      end
      default: ac_n = dr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      e_q  <= 1'b0;
    end else begin
      if (clr[RG_AR])      ar_q <= '0;
      else if (ld[LD_AR])  ar_q <= bus[AW-1:0];
      else if (inr[RG_AR]) ar_q <= ar_q + AW'(1);

      if (clr[RG_PC])      pc_q <= '0;
      else if (ld[LD_PC])  pc_q <= bus[AW-1:0];
      else if (inr[RG_PC]) pc_q <= pc_q + AW'(1);

      if (clr[RG_DR])      dr_q <= '0;
      else if (ld[LD_DR])  dr_q <= bus;
      else if (inr[RG_DR]) dr_q <= dr_q + DW'(1);

      // E only moves when an AC load actually takes effect
      if (clr[RG_AC]) begin
        ac_q <= '0;
      end else if (ld[LD_AC]) begin
        ac_q <= ac_n;
        e_q  <= e_n;
      end else if (inr[RG_AC]) begin
        ac_q <= ac_q + DW'(1);
      end

      if (ld[LD_IR]) ir_q <= bus;
    end
  end

  assign mem.mem_addr  = ar_q;
  assign mem.mem_wdata = bus;
  assign mem.mem_re    = Read;
  assign mem.mem_we    = Write;

  assign ir = ir_q;
  assign ac = ac_q;
  assign e  = e_q;

endmodule
